// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word geometry, sigma functions
// and the scheduler state encoding.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int MAX_ROUNDS  = 64;
  localparam int T_IDX_W     = 6;
  localparam int K_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_next.sv
// Combinational schedule recurrence: builds the word that enters the top of
// the 16-word window from the four taps W[t], W[t+1], W[t+9], W[t+14].
module sha256_sched_next
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] r0,
  input  logic [WORD_W-1:0] r1,
  input  logic [WORD_W-1:0] r9,
  input  logic [WORD_W-1:0] r14,
  output logic [WORD_W-1:0] r15
);

  // Plain 32-bit adds: carries out of bit 31 are dropped by width.
  assign r15 = sig1(r14) + r9 + sig0(r1) + r0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads one 16-word block, then streams
// W_0..W_{ROUNDS-1} on a valid/ready interface using a shifting window.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 64
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [T_IDX_W-1:0] t_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [T_IDX_W-1:0] T_LAST = T_IDX_W'(ROUNDS - 1);
  localparam logic [K_W-1:0]     K_LAST = K_W'(BLOCK_WORDS - 1);

  if (DATA_W != WORD_W || ROUNDS < BLOCK_WORDS || ROUNDS > MAX_ROUNDS) begin : g_cfg_err
    $error("sha256_msg_sched: DATA_W must be 32 and ROUNDS must be 16..64");
  end

  sched_state_e       state;
  logic [DATA_W-1:0]  win [BLOCK_WORDS];
  logic [K_W-1:0]     k_cnt;
  logic [T_IDX_W-1:0] t_cnt;
  logic [DATA_W-1:0]  w_next;
  logic               load_acc;
  logic               emit_acc;

  assign load_acc = in_valid & in_ready;
  assign emit_acc = out_valid & out_ready;
  assign out0     = win[0];
  assign t_idx    = t_cnt;

  sha256_sched_next u_next (
    .r0  (win[0]),
    .r1  (win[1]),
    .r9  (win[9]),
    .r14 (win[14]),
    .r15 (w_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k_cnt     <= '0;
      t_cnt     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (load_acc) begin
            win[k_cnt] <= in0;
            k_cnt      <= k_cnt + 1'b1;
            if (k_cnt == K_LAST) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          // Each accepted word slides the window; the surplus words computed
          // on the final shifts are simply never presented.
          if (emit_acc) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
            win[BLOCK_WORDS-1] <= w_next;
            if (t_cnt == T_LAST) begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          t_cnt <= '0;
          k_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched and its recurrence sub-module.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, in_valid, out_ready;
  logic [31:0] in0;
  logic        in_ready, out_valid, busy, done;
  logic [31:0] out0;
  logic [5:0]  t_idx;

  logic        run_b, in_valid_b, out_ready_b;
  logic [31:0] in0_b;
  logic        in_ready_b, out_valid_b, busy_b, done_b;
  logic [31:0] out0_b;
  logic [5:0]  t_idx_b;

  logic [31:0] n_r0, n_r1, n_r9, n_r14, n_r15;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_msg_sched #(.DATA_W(32), .ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0), .in_valid(in_valid),
    .in_ready(in_ready), .out0(out0), .out_valid(out_valid),
    .out_ready(out_ready), .t_idx(t_idx), .busy(busy), .done(done)
  );

  sha256_msg_sched #(.DATA_W(32), .ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .run(run_b), .in0(in0_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .out0(out0_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .t_idx(t_idx_b), .busy(busy_b), .done(done_b)
  );

  sha256_sched_next u_next (
    .r0(n_r0), .r1(n_r1), .r9(n_r9), .r14(n_r14), .r15(n_r15)
  );

  typedef struct {
    logic [31:0] r0, r1, r9, r14, r15;
  } next_vec_t;

  typedef struct {
    int          t;
    logic [31:0] w;
  } abc_pt_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0m(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1m(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = s1m(exp_w[t-2]) + exp_w[t-7] + s0m(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic do_run(output int run_cyc);
    @(negedge clk);
    run = 1'b1;
    run_cyc = cyc;
  endtask

  // Feeds blk[0..15]; returns the cycle index of the 16th acceptance.
  task automatic load_block(input bit gaps, input bit pulse_run, output int acc_cyc);
    int k = 0;
    int guard = 0;
    bit v;
    acc_cyc = -1;
    while (k < 16 && guard < 200) begin
      @(negedge clk);
      run = pulse_run && (k == 5);
      check("in_ready_load", 32'(in_ready), 32'd1);
      v = gaps ? (guard % 2 == 0) : 1'b1;
      in_valid = v;
      in0 = blk[k];
      if (v && in_ready) begin
        k++;
        acc_cyc = cyc;
      end
      guard++;
    end
    check("load_count", 32'(k), 32'd16);
  endtask

  task automatic collect(input int n, input bit bp, input bit pulse_run,
                         input int abort_t, output int done_cyc);
    int got = 0;
    int guard = 0;
    bit stalled = 0;
    logic [31:0] held_w;
    logic [5:0]  held_t;
    done_cyc = -1;
    while (got < n && guard < 2000) begin
      @(negedge clk);
      in_valid = 1'b0;
      in0 = 32'hDEAD_0000 + 32'(guard);
      run = pulse_run && (got == 20);
      if (guard == 0) check("in_ready_emit", 32'(in_ready), 32'd0);
      check("out_valid_hi", 32'(out_valid), 32'd1);
      if (stalled) begin
        check("stall_out0", out0, held_w);
        check("stall_t_idx", 32'(t_idx), 32'(held_t));
      end
      if (got == abort_t) begin
        check("t_idx_abort", 32'(t_idx), 32'(abort_t));
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out0", out0, 32'd0);
        check("rst_t_idx", 32'(t_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        return;
      end
      check($sformatf("w[%0d]", got), out0, exp_w[got]);
      check($sformatf("t_idx[%0d]", got), 32'(t_idx), 32'(got));
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        got_w[got] = out0;
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_w = out0;
        held_t = t_idx;
      end
      guard++;
    end
    check("emit_count", 32'(got), 32'(n));
    @(negedge clk);
    run = pulse_run;
    out_ready = 1'b1;
    check("done_pulse", 32'(done), 32'd1);
    check("out_valid_after_last", 32'(out_valid), 32'd0);
    done_cyc = cyc;
    @(negedge clk);
    run = 1'b0;
    check("done_width", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd0);
  endtask

  next_vec_t nv [7];
  abc_pt_t   ap [6];

  initial begin
    int run_cyc, acc_cyc, done_cyc;

    nv[0] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    nv[1] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h61626380};
    nv[2] = '{32'h0, 32'h0, 32'h0, 32'h00000018, 32'h000F0000};
    nv[3] = '{32'h0, 32'h00000008, 32'h0, 32'h0, 32'h10020001};
    nv[4] = '{32'h0, 32'h0, 32'h0, 32'h00000400, 32'h02800001};
    nv[5] = '{32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    nv[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h203FFFFC};

    ap[0] = '{0,  32'h61626380};
    ap[1] = '{1,  32'h00000000};
    ap[2] = '{14, 32'h00000000};
    ap[3] = '{15, 32'h00000018};
    ap[4] = '{16, 32'h61626380};
    ap[5] = '{17, 32'h000F0000};

    rst = 1'b0;
    run = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in0 = '0;
    run_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1; in0_b = '0;
    n_r0 = '0; n_r1 = '0; n_r9 = '0; n_r14 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_out0", out0, 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_t_idx", 32'(t_idx), 32'd0);
    rst = 1'b1;

    // Recurrence unit vectors
    for (int i = 0; i < 7; i++) begin
      n_r0 = nv[i].r0; n_r1 = nv[i].r1; n_r9 = nv[i].r9; n_r14 = nv[i].r14;
      #1;
      check($sformatf("next_vec%0d", i), n_r15, nv[i].r15);
    end

    // "abc" block, full throughput
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
    do_run(run_cyc);
    load_block(1'b0, 1'b0, acc_cyc);
    collect(64, 1'b0, 1'b0, -1, done_cyc);
    check("run_to_done_cycles", 32'(done_cyc - run_cyc + 1), 32'd82);
    for (int i = 0; i < 6; i++)
      check($sformatf("abc_W%0d", ap[i].t), got_w[ap[i].t], ap[i].w);

    // Random backpressure, same block
    do_run(run_cyc);
    load_block(1'b0, 1'b0, acc_cyc);
    collect(64, 1'b1, 1'b0, -1, done_cyc);

    // in_valid gaps during LOAD
    do_run(run_cyc);
    load_block(1'b1, 1'b0, acc_cyc);
    collect(64, 1'b0, 1'b0, -1, done_cyc);

    // Reset mid-EMIT at t=30, then a clean rerun
    do_run(run_cyc);
    load_block(1'b0, 1'b0, acc_cyc);
    collect(64, 1'b0, 1'b0, 30, done_cyc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_run(run_cyc);
    load_block(1'b0, 1'b0, acc_cyc);
    collect(64, 1'b0, 1'b0, -1, done_cyc);

    // Stray in_valid in IDLE, run pulses during LOAD/EMIT/DONE
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in0 = 32'hDEADBEEF;
      check("in_ready_idle_stray", 32'(in_ready), 32'd0);
    end
    do_run(run_cyc);
    load_block(1'b0, 1'b1, acc_cyc);
    collect(64, 1'b0, 1'b1, -1, done_cyc);
    check("run_to_done_pulsed", 32'(done_cyc - run_cyc + 1), 32'd82);

    // ROUNDS=16 instance, all-ones block
    @(negedge clk);
    run_b = 1'b1;
    @(negedge clk);
    run_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("r16_in_ready", 32'(in_ready_b), 32'd1);
      in_valid_b = 1'b1;
      in0_b = 32'hFFFFFFFF;
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("r16_out_valid", 32'(out_valid_b), 32'd1);
      check($sformatf("r16_w[%0d]", i), out0_b, 32'hFFFFFFFF);
      check($sformatf("r16_t_idx[%0d]", i), 32'(t_idx_b), 32'(i));
      @(negedge clk);
    end
    check("r16_done", 32'(done_b), 32'd1);
    check("r16_out_valid_end", 32'(out_valid_b), 32'd0);
    @(negedge clk);
    check("r16_done_width", 32'(done_b), 32'd0);
    check("r16_busy_idle", 32'(busy_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Message-schedule producer for the SHA-256 datapath. It is the upstream end of the round interface: it supplies the W_t stream that the T1/T2 round units consume alongside the working variables.
- A run pulse arms the block. It then accepts one 512-bit block as 16 words and emits W_0..W_{ROUNDS-1} on a valid/ready stream, one word per handshake.
- W_0..W_15 are pass-through. Later words use the standard σ0/σ1 recurrence.

Parameters:
- DATA_W, 32, word width; must be 32, any other value is a configuration error.
- ROUNDS, 64, number of W words emitted per block; legal range 16..64.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  start pulse; sampled only in IDLE.
- in0  input  DATA_W  input message word (big-endian word order, word 0 first).
- in_valid  input  1  in0 is valid.
- in_ready  output  1  block accepts in0 this cycle.
- out0  output  DATA_W  W_t.
- out_valid  output  1  out0 is valid.
- out_ready  input  1  consumer accepts out0.
- t_idx  output  6  round index t of the word currently on out0.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE.
  - window R[0..15]=0, load counter=0, t_idx=0.
  - in_ready=0, out_valid=0, busy=0, done=0, out0=0.
- State machine:
  - IDLE: run=1 moves to LOAD next cycle. run in any other state is ignored.
  - LOAD:
    - in_ready=1.
    - Each in_valid&in_ready cycle writes in0 to R[k], k=0..15, and increments k.
    - Acceptance of k=15 moves to EMIT next cycle; in_ready drops in that same transition.
    - Stalls indefinitely without in_valid.
  - EMIT:
    - out_valid=1, out0=R[0], t_idx=t.
    - On out_valid&out_ready:
      - Shift R[i]<=R[i+1] for i=0..14.
      - R[15] <= σ1(R[14]) + R[9] + σ0(R[1]) + R[0], mod 2^32.
      - t increments.
    - This yields W_{t+16} from W_t..W_{t+15}, so the emitted sequence is W_0..W_{ROUNDS-1} with no extra latency.
    - Shifts continue past t=48; surplus computed words are never emitted.
    - Acceptance of t=ROUNDS-1 moves to DONE.
  - DONE:
    - done=1 for exactly one cycle, out_valid=0.
    - Then return to IDLE, clearing t and k.
- Function definitions:
  - σ0(x)=ROTR7(x)^ROTR18(x)^SHR3(x).
  - σ1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
  - All additions are 32-bit wrap-around; carries are discarded.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out0 and t_idx hold stable.
  - out_valid never drops before acceptance.
  - The first out_valid is asserted the cycle after the 16th input is accepted.
  - At full throughput (out_ready held 1) one word is emitted per cycle: the block takes 16+ROUNDS+2 cycles from run to done.
- Simultaneous events:
  - run during DONE is ignored; it must be reissued in IDLE.
  - in_valid outside LOAD is ignored; in_ready=0.
- Reset mid-operation discards the partial block; the next run restarts from W_0.

Decomposition:
- Shared package sha256_pkg holds:
  - constants: word width 32, block words 16, max rounds 64, t_idx width 6;
  - the σ0 and σ1 functions;
  - the state encoding IDLE/LOAD/EMIT/DONE.
- One natural sub-module: sha256_sched_next. It is combinational and maps the four window taps R[0], R[1], R[9], R[14] to the new R[15]. It can be unit-tested standalone.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 throughout. Required response:
  - W16=0x61626380, W17=0x000F0000;
  - 64 words emitted;
  - done pulses exactly one cycle, 82 cycles after run.
- Random out_ready backpressure with the same block: sequence identical to the previous scenario; out0/t_idx stable across every stall cycle; no word dropped or duplicated.
- in_valid gaps during LOAD (every other cycle): exactly 16 words captured; first out_valid the cycle after the 16th acceptance.
- ROUNDS=16, all-ones input: outputs are 16× 0xFFFFFFFF, then done; no computed word appears.
- rst asserted at t=30 mid-EMIT: all outputs are 0 immediately (asynchronous). Reissued run and block reproduce W_0 onward.
- run pulsed during LOAD and during EMIT: no effect on the sequence or counters; in0 driven with in_valid=1 in IDLE is not captured.
